// File: rtl/asrm_bus_arbiter.sv
// asrm_bus_arbiter
//
// Two-master round-robin arbiter in front of a single shared system bus with a
// fixed read latency. One transaction is in flight at a time:
//   IDLE   -> sample requests, pick a master, latch its address/data/direction
//   ACCESS -> drive the latched access for ram_latency cycles, capture read data
//             on the last one
//   DONE   -> one-cycle ack to the granted master, record it as last grant
//
// Parameters
//   wordsize     width of every address and data bus
//   ram_latency  cycles from address presentation to valid data_in (1..15)
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous active-high reset
//   mN_req/addr/wdata/we  request from master N (req held until mN_ack)
//   mN_rdata              last read data returned to master N
//   mN_ack                one-cycle completion pulse to master N
//   addr/data_out         shared bus address and write data
//   write_en              shared bus write strobe
//   data_in               shared bus read data
//   busy                  high whenever a transaction is in flight
module asrm_bus_arbiter #(
    parameter int unsigned wordsize    = 16,
    parameter int unsigned ram_latency = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_req,
    input  logic [wordsize-1:0] m0_addr,
    input  logic [wordsize-1:0] m0_wdata,
    input  logic                m0_we,
    output logic [wordsize-1:0] m0_rdata,
    output logic                m0_ack,

    input  logic                m1_req,
    input  logic [wordsize-1:0] m1_addr,
    input  logic [wordsize-1:0] m1_wdata,
    input  logic                m1_we,
    output logic [wordsize-1:0] m1_rdata,
    output logic                m1_ack,

    output logic [wordsize-1:0] addr,
    output logic [wordsize-1:0] data_out,
    output logic                write_en,
    input  logic [wordsize-1:0] data_in,
    output logic                busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    // Countdown is 4 bits wide, enough for the legal latency range of 1..15.
    localparam logic [3:0] CntInit = 4'(ram_latency - 1);

    state_e              state_q, state_d;
    logic                grant_q, grant_d;          // 0: master 0, 1: master 1
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [wordsize-1:0] addr_q, addr_d;
    logic [wordsize-1:0] dout_q, dout_d;
    logic [wordsize-1:0] rdata0_q, rdata0_d;
    logic [wordsize-1:0] rdata1_q, rdata1_d;

    logic                sel;

    // Winner of the current IDLE cycle: a lone requester wins outright; on a
    // tie the master that was not served last time wins.
    always_comb begin
        if (m0_req && m1_req) begin
            sel = ~last_grant_q;
        end else begin
            sel = m1_req;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    grant_d = sel;
                    addr_d  = sel ? m1_addr  : m0_addr;
                    dout_d  = sel ? m1_wdata : m0_wdata;
                    we_d    = sel ? m1_we    : m0_we;
                    cnt_d   = CntInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Last access cycle: data_in is valid now.
                    if (!we_q) begin
                        if (grant_q) begin
                            rdata1_d = data_in;
                        end else begin
                            rdata0_d = data_in;
                        end
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                // No grant here; a still-asserted request is seen next IDLE.
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // master 0 wins the first tie
            we_q         <= 1'b0;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            dout_q       <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them
    // without waiting for a clock edge.
    always_comb begin
        addr     = addr_q;
        data_out = dout_q;
        m0_rdata = rdata0_q;
        m1_rdata = rdata1_q;
        write_en = (state_q == StAccess) && we_q;
        m0_ack   = (state_q == StDone) && !grant_q;
        m1_ack   = (state_q == StDone) && grant_q;
        busy     = (state_q != StIdle);
    end

endmodule

// File: tb/tb_asrm_bus_arbiter.sv
// Randomized bench for asrm_bus_arbiter. Two instances run side by side, one
// with ram_latency=1 and one with ram_latency=3, each with its own masters.
// A transaction-level reference model tracks the in-flight transfer as
// "cycles elapsed since grant" and derives every expected output from it.
module tb_asrm_bus_arbiter;

    localparam int unsigned W    = 16;
    localparam int          NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         m0_req[2], m1_req[2], m0_we[2], m1_we[2];
    logic [W-1:0] m0_addr[2], m0_wdata[2], m1_addr[2], m1_wdata[2], data_in[2];
    logic [W-1:0] m0_rdata[2], m1_rdata[2], addr[2], data_out[2];
    logic         m0_ack[2], m1_ack[2], write_en[2], busy[2];

    asrm_bus_arbiter #(.wordsize(W), .ram_latency(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]), .m0_we(m0_we[0]),
        .m0_rdata(m0_rdata[0]), .m0_ack(m0_ack[0]),
        .m1_req(m1_req[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]), .m1_we(m1_we[0]),
        .m1_rdata(m1_rdata[0]), .m1_ack(m1_ack[0]),
        .addr(addr[0]), .data_out(data_out[0]), .write_en(write_en[0]),
        .data_in(data_in[0]), .busy(busy[0])
    );

    asrm_bus_arbiter #(.wordsize(W), .ram_latency(3)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]), .m0_we(m0_we[1]),
        .m0_rdata(m0_rdata[1]), .m0_ack(m0_ack[1]),
        .m1_req(m1_req[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]), .m1_we(m1_we[1]),
        .m1_rdata(m1_rdata[1]), .m1_ack(m1_ack[1]),
        .addr(addr[1]), .data_out(data_out[1]), .write_en(write_en[1]),
        .data_in(data_in[1]), .busy(busy[1])
    );

    // Reference model state, per instance.
    bit           m_inflight[2];
    int           m_el[2];       // cycles since the grant edge; DONE at lat+1
    int           m_own[2];
    bit           m_we[2];
    logic [W-1:0] m_addr[2], m_dout[2], m_rd0[2], m_rd1[2];
    int           m_last[2];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_inflight[k] = 1'b0;
        m_el[k]       = 0;
        m_own[k]      = 0;
        m_we[k]       = 1'b0;
        m_addr[k]     = '0;
        m_dout[k]     = '0;
        m_rd0[k]      = '0;
        m_rd1[k]      = '0;
        m_last[k]     = 1;
    endtask

    function automatic bit exp_ack(input int k, input int n);
        return m_inflight[k] && (m_el[k] == lat_of(k) + 1) && (m_own[k] == n);
    endfunction

    function automatic bit exp_wen(input int k);
        return m_inflight[k] && (m_el[k] >= 1) && (m_el[k] <= lat_of(k)) && m_we[k];
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step(input int k);
        int s;
        if (!m_inflight[k]) begin
            if (m0_req[k] || m1_req[k]) begin
                if (m0_req[k] && m1_req[k]) s = 1 - m_last[k];
                else                        s = m0_req[k] ? 0 : 1;
                m_own[k]      = s;
                m_addr[k]     = (s == 1) ? m1_addr[k]  : m0_addr[k];
                m_dout[k]     = (s == 1) ? m1_wdata[k] : m0_wdata[k];
                m_we[k]       = (s == 1) ? m1_we[k]    : m0_we[k];
                m_inflight[k] = 1'b1;
                m_el[k]       = 1;
            end
        end else if (m_el[k] == lat_of(k) + 1) begin
            m_inflight[k] = 1'b0;
            m_last[k]     = m_own[k];
        end else begin
            if (m_el[k] == lat_of(k) && !m_we[k]) begin
                if (m_own[k] == 1) m_rd1[k] = data_in[k];
                else               m_rd0[k] = data_in[k];
            end
            m_el[k]++;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            string pre;
            pre = $sformatf("L%0d", lat_of(k));
            check_val({pre, ".busy"},     32'(busy[k]),     32'(m_inflight[k]));
            check_val({pre, ".write_en"}, 32'(write_en[k]), 32'(exp_wen(k)));
            check_val({pre, ".m0_ack"},   32'(m0_ack[k]),   32'(exp_ack(k, 0)));
            check_val({pre, ".m1_ack"},   32'(m1_ack[k]),   32'(exp_ack(k, 1)));
            check_val({pre, ".ack_excl"}, 32'(m0_ack[k] & m1_ack[k]), 32'd0);
            check_val({pre, ".addr"},     32'(addr[k]),     32'(m_addr[k]));
            check_val({pre, ".data_out"}, 32'(data_out[k]), 32'(m_dout[k]));
            check_val({pre, ".m0_rdata"}, 32'(m0_rdata[k]), 32'(m_rd0[k]));
            check_val({pre, ".m1_rdata"}, 32'(m1_rdata[k]), 32'(m_rd1[k]));
        end
    endtask

    // Master protocol: hold req until ack; after ack optionally keep requesting;
    // occasionally drop req once the transfer is already granted.
    function automatic logic pick_req(input logic cur, input bit acked, input bit granted,
                                      input bit force_on);
        if (force_on)     return 1'b1;
        if (cur) begin
            if (acked)    return 1'($urandom_range(0, 1));
            if (granted && $urandom_range(0, 7) == 0) return 1'b0;
            return 1'b1;
        end
        return 1'($urandom_range(0, 2) == 0);
    endfunction

    task automatic drive_inputs(input int k, input bit force_both);
        bit g0, g1;
        g0 = m_inflight[k] && m_own[k] == 0;
        g1 = m_inflight[k] && m_own[k] == 1;
        m0_req[k]   = pick_req(m0_req[k], exp_ack(k, 0), g0, force_both);
        m1_req[k]   = pick_req(m1_req[k], exp_ack(k, 1), g1, force_both);
        // Address/data/direction wander every cycle; only the grant edge matters.
        m0_addr[k]  = W'($urandom);
        m0_wdata[k] = W'($urandom);
        m0_we[k]    = 1'($urandom_range(0, 1));
        m1_addr[k]  = W'($urandom);
        m1_wdata[k] = W'($urandom);
        m1_we[k]    = 1'($urandom_range(0, 1));
        data_in[k]  = W'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m0_req[k] = 1'b0; m1_req[k] = 1'b0; m0_we[k] = 1'b0; m1_we[k] = 1'b0;
            m0_addr[k] = '0; m0_wdata[k] = '0; m1_addr[k] = '0; m1_wdata[k] = '0;
            data_in[k] = '0;
            model_reset(k);
        end
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (reset) reset = 1'b0;   // release a pulse held across one edge
            compare_all();
            for (int k = 0; k < 2; k++) drive_inputs(k, cyc < 40);
            if (cyc > 60 && $urandom_range(0, 49) == 0) begin
                // Asynchronous reset mid-cycle: outputs must clear immediately.
                reset = 1'b1;
                #1;
                for (int k = 0; k < 2; k++) model_reset(k);
                compare_all();
            end else begin
                for (int k = 0; k < 2; k++) model_step(k);
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
